// File: rtl/pipeline_hazard_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller_pkg
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_t : controller FSM state (RUN, FLUSH, MEM_WAIT)
//   CNT_W          : width of the event counters
//   REG_W          : width of a register-file index
// -----------------------------------------------------------------------------
package pipeline_hazard_controller_pkg;

    localparam int CNT_W = 16;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use comparator: flags when the ID-stage
// instruction reads a register that the EX-stage load has not yet produced.
// Ports:
//   ex_valid, ex_dm_rd, ex_rd       : EX-stage instruction (valid, is load, rd)
//   id_rs1, id_rs2                  : ID-stage source registers
//   id_use_rs1, id_use_rs2          : ID-stage instruction actually reads rs1/rs2
//   hazard                          : 1 when ID must wait one cycle for the load
// -----------------------------------------------------------------------------
module load_use_detect
    import pipeline_hazard_controller_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_dm_rd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign hazard = ex_valid && ex_dm_rd && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Stage-register enable / flush generation for a 5-stage pipeline, covering
// data-memory wait stalls, taken-branch redirects (with a one-cycle bubble for
// the synchronous instruction memory) and load-use stalls.
// Event priority: memory wait > branch redirect > load-use.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   nextPcSrc, exValid               : EX-stage redirect decision and validity
//   exDmRd, exRd                     : EX-stage load flag and destination
//   idRs1, idRs2, idUseRs1, idUseRs2 : ID-stage source operands
//   dmReq, dmReady                   : MEM-stage data-memory handshake
//   pcWrite, ifIdWrite, idExWrite,
//   exMemWrite                       : stage-register enables
//   ifIdFlush, idExFlush             : bubble insertion into IF/ID, ID/EX
//   branchTakenCnt, stallCnt         : wrapping event counters
// All control outputs are combinational from state and inputs.
// -----------------------------------------------------------------------------
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             nextPcSrc,
    input  logic             exValid,
    input  logic             exDmRd,
    input  logic [REG_W-1:0] exRd,
    input  logic [REG_W-1:0] idRs1,
    input  logic [REG_W-1:0] idRs2,
    input  logic             idUseRs1,
    input  logic             idUseRs2,
    input  logic             dmReq,
    input  logic             dmReady,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExWrite,
    output logic             exMemWrite,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic [CNT_W-1:0] branchTakenCnt,
    output logic [CNT_W-1:0] stallCnt
);

    hazard_state_t    state;
    hazard_state_t    state_next;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic load_use;
    logic mem_wait;
    logic redirect;
    logic stall_inc;
    logic taken_inc;

    load_use_detect u_load_use_detect (
        .ex_valid   (exValid),
        .ex_dm_rd   (exDmRd),
        .ex_rd      (exRd),
        .id_rs1     (idRs1),
        .id_rs2     (idRs2),
        .id_use_rs1 (idUseRs1),
        .id_use_rs2 (idUseRs2),
        .hazard     (load_use)
    );

    // Once waiting, only dmReady releases the stall; outside MEM_WAIT a new
    // wait needs an outstanding request.
    assign mem_wait = (state == MEM_WAIT) ? !dmReady : (dmReq && !dmReady);

    // The FLUSH cycle ignores nextPcSrc: the EX instruction is the bubble
    // already inserted by the previous redirect.
    assign redirect = (state != FLUSH) && nextPcSrc && exValid && !mem_wait;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        exMemWrite = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        state_next = RUN;
        stall_inc  = 1'b0;
        taken_inc  = 1'b0;

        if (rst) begin
            // Freeze every stage and fill IF/ID and ID/EX with bubbles.
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
        end else if (mem_wait) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            state_next = MEM_WAIT;
            stall_inc  = 1'b1;
        end else if (redirect) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            state_next = FLUSH;
            taken_inc  = 1'b1;
        end else begin
            // The cycle after a redirect fetches from the new PC, but the
            // synchronous instruction memory has not delivered it yet.
            ifIdFlush = (state == FLUSH);
            if (load_use) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                idExFlush = 1'b1;
                stall_inc = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state <= state_next;
            if (taken_inc) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign branchTakenCnt = taken_cnt_q;
    assign stallCnt       = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock and reset are named as the codebase does.
REQ-002 clk  in  1  pipeline clock; all state updates occur on its rising edge.
REQ-003 rst  in  1  reset; asynchronous assert, active-high.
REQ-004 nextPcSrc  in  1  taken-branch/jump decision for the EX-stage instruction, from the branch-resolution unit.
REQ-005 exValid  in  1  EX stage holds a real instruction, not a bubble.
REQ-006 exDmRd  in  1  EX instruction is a load.
REQ-007 exRd  in  5  EX destination register.
REQ-008 idRs1, idRs2  in  5 each  ID source registers.
REQ-009 idUseRs1, idUseRs2  in  1 each  ID instruction reads rs1/rs2.
REQ-010 dmReq  in  1  MEM stage issues a data-memory access.
REQ-011 dmReady  in  1  data memory completes the access this cycle.
REQ-012 pcWrite, ifIdWrite, idExWrite, exMemWrite  out  1 each  stage-register enables.
REQ-013 ifIdFlush, idExFlush  out  1 each  load a bubble into IF/ID or ID/EX.
REQ-014 branchTakenCnt  out  16  count of taken redirects.
REQ-015 stallCnt  out  16  count of stall cycles: load-use plus memory-wait.

Function
REQ-016 FSM states: RUN, FLUSH, MEM_WAIT.
REQ-017 Priority when events coincide, highest first: memory wait, branch redirect, load-use.
REQ-018 Memory wait occurs when dmReq=1 and dmReady=0, in any state.
- All four write enables = 0; both flushes = 0.
- Next state = MEM_WAIT.
- stallCnt increments.
REQ-019 MEM_WAIT holds while dmReady=0.
- When dmReady=1, that cycle behaves as RUN, including redirect evaluation.
- Next state = RUN, or FLUSH if a redirect occurs.
REQ-020 Redirect occurs in RUN when nextPcSrc=1 and exValid=1 and there is no memory wait.
- pcWrite=1; ifIdFlush=1; idExFlush=1; other enables = 1.
- Next state = FLUSH.
- branchTakenCnt increments.
REQ-021 FLUSH lasts exactly one cycle, covering the synchronous instruction-memory bubble.
- ifIdFlush=1; idExFlush=0; all enables = 1.
- nextPcSrc is ignored.
- Next state = RUN, or MEM_WAIT if a memory wait is present.
REQ-022 Load-use hazard:
- Condition: exDmRd=1, exValid=1, exRd!=0, and ((idUseRs1 and idRs1==exRd) or (idUseRs2 and idRs2==exRd)).
- Effect in RUN with no redirect: pcWrite=0, ifIdWrite=0, idExFlush=1; idExWrite=1, exMemWrite=1.
- Stays in RUN; stallCnt increments.
REQ-023 A redirect and a load-use hazard in the same cycle: the redirect wins and stallCnt does not increment.
REQ-024 A hazard and a redirect arising in FLUSH: the hazard is evaluated and a redirect is ignored.
REQ-025 In RUN with no event, all enables = 1 and both flushes = 0.
REQ-026 All outputs are combinational from state and inputs; detection-to-effect latency is 0 cycles.
REQ-027 Both counters are 16-bit and wrap from 0xFFFF to 0x0000.

Reset
REQ-028 While rst=1:
- state = RUN; both counters = 0.
- All four enables = 0; ifIdFlush=1; idExFlush=1.
REQ-029 Reset asserted mid-FLUSH or mid-MEM_WAIT aborts immediately; the first cycle after deassertion is RUN.

Structure
REQ-030 A shared package SHALL hold the state enum (hazard_state_t) and CNT_W=16.
REQ-031 The load-use comparator SHALL be one combinational sub-module, load_use_detect.

Verification
REQ-032 Taken branch:
- Stimulus: exValid=1, nextPcSrc=1 in RUN.
- Same cycle: pcWrite=1, ifIdFlush=1, idExFlush=1.
- Next cycle: ifIdFlush=1, idExFlush=0.
- branchTakenCnt 0->1.
REQ-033 Load-use:
- Stimulus: exDmRd=1, exRd=5, idRs2=5, idUseRs2=1.
- Response: pcWrite=0, ifIdWrite=0, idExFlush=1 for one cycle; stallCnt=1.
- Repeat with exRd=0: no stall.
REQ-034 Memory wait:
- Stimulus: dmReq=1, dmReady=0 for 3 cycles, then dmReady=1.
- Response: all enables 0 for 3 cycles, stallCnt=3, then RUN.
REQ-035 Simultaneous events:
- Redirect and load-use together: redirect behaviour, stallCnt unchanged.
- Redirect during a memory wait: deferred to the dmReady=1 cycle.
REQ-036 Reset and wrap:
- rst asserted during MEM_WAIT: RUN and counters 0 immediately.
- branchTakenCnt preloaded to 0xFFFF by 65535 redirects, plus one more: reads 0x0000.
